mcpu_program_sequencer: RTL
===========================

Name: mcpu_program_sequencer

Overview:
- Instruction sequencer sitting directly upstream of the 4-bit accumulator CPU.
- Stores a small program of CPU instructions and replays it by driving the CPU's opcode, data, address and write-enable inputs.
- Holds each instruction stable long enough for the CPU's decode-then-execute FSM.
- Adds HALT and JUMP control opcodes that are consumed here and never forwarded to the CPU.

Parameters:
- ADDR_W, 4: program counter width; program depth = 2**ADDR_W words.
- HOLD_CYCLES, 3: cycles each instruction is presented to the CPU. Legal range 2..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- prog_we  in  1  program-memory write strobe.
- prog_addr  in  ADDR_W  program-memory write address.
- prog_wdata  in  13  instruction word {opcode[12:9], data[8:5], addr[4:1], we[0]}.
- start  in  1  pulse: run from PC 0, or resume from PAUSE.
- halt  in  1  pulse: abort and return to IDLE.
- step_mode  in  1  1 = pause after every issued instruction.
- cpu_opcode  out  4  to CPU opcode input.
- cpu_data  out  4  to CPU data input.
- cpu_addr  out  4  to CPU address input.
- cpu_we  out  1  to CPU write-enable input.
- issue_valid  out  1  high while an instruction is presented.
- busy  out  1  high in FETCH, ISSUE or PAUSE.
- done  out  1  high in DONE.
- pc  out  ADDR_W  current program counter.

Behaviour:
- Reset values: state IDLE, pc=0, cpu_opcode=4'b1011 (NOP), cpu_data=0, cpu_addr=0, cpu_we=0, issue_valid=0, busy=0, done=0, hold counter=0.
- Program memory is not reset; the bench must load it before running.
- Outside ISSUE, outputs idle at NOP/0/0/0.
- States: IDLE, FETCH, ISSUE, PAUSE, DONE.
- IDLE, or DONE, + start -> FETCH with pc<=0.
- FETCH (1 cycle): registered read of mem[pc] into the instruction register, then decode:
  - opcode 1111 (HALT) -> DONE; pc unchanged.
  - opcode 1110 (JUMP) -> FETCH with pc<=addr field, low ADDR_W bits zero-extended or truncated. Nothing is issued.
  - any other opcode -> ISSUE.
- ISSUE: drive cpu_* from the instruction register with issue_valid=1 for exactly HOLD_CYCLES cycles. cpu_we carries the word's we bit.
- On the last ISSUE cycle: pc<=pc+1, wrapping from 2**ADDR_W-1 to 0. Next state is PAUSE if step_mode=1, else FETCH.
- PAUSE + start -> FETCH.
- Latency: start sampled at edge k gives FETCH in cycle k+1 and the first issue cycles k+2..k+1+HOLD_CYCLES. Steady-state cost is HOLD_CYCLES+1 cycles per instruction and 1 cycle per JUMP.
- halt: from any state, next state is IDLE, outputs go to NOP, pc is kept.
- halt has priority over start and over any in-progress ISSUE.
- start is ignored in FETCH and ISSUE.
- prog_we is accepted only in IDLE, PAUSE and DONE; it is ignored while in FETCH or ISSUE. A write is visible to a FETCH on the next cycle.
- Write and FETCH of the same address in the same cycle cannot occur, because writes are blocked in FETCH.
- Async reset mid-ISSUE: all outputs return to reset values immediately, without waiting for a clock edge.
- A JUMP-to-self loop runs forever and is left only via halt or reset.

Optional Feature:
- Macro: MCPU_SEQ_BREAKPOINT_EN.
- Enabled: adds inputs bp_en (1) and bp_addr (ADDR_W).
  - In FETCH, when bp_en=1 and pc==bp_addr, go to PAUSE instead of decoding. Output bp_hit pulses for 1 cycle.
  - The following start decodes that word without re-checking the breakpoint.
- Disabled: ports absent; FETCH always decodes.

Test Plan:
- Load mem0={0011,0,5,0} (LOAD addr5), mem1={0000,3,0,0} (ADD 3), mem2=HALT; pulse start at edge 0 -> cpu_opcode=0011 with issue_valid=1 in cycles 2-4, 0000 in cycles 6-8, done=1 from cycle 10, pc=2.
- mem0={0110,F,0,0}, mem1=JUMP addr0 -> opcode 0110 issued repeatedly with a period of 5 cycles; pulse halt mid-ISSUE -> next cycle outputs NOP, issue_valid=0, busy=0.
- step_mode=1 with a 3-word program -> PAUSE after each issue with pc=1, then 2; each start yields exactly one 3-cycle issue.
- Fill all 16 words with non-control opcodes and run -> pc wraps from 15 to 0 with no stall; prog_we during ISSUE leaves memory unchanged.
- Assert rst_n low during ISSUE -> cpu_we=0 and cpu_opcode=1011 immediately; after release, state is IDLE and pc=0.
- Breakpoint build: bp_en=1, bp_addr=1 -> PAUSE with bp_hit after word 0 issues; start -> word 1 issues.

Source files
------------

// File: rtl/mcpu_program_sequencer.sv
// Program store and replay sequencer feeding the 4-bit accumulator CPU.
// Optional breakpoint support: define MCPU_SEQ_BREAKPOINT_EN.
module mcpu_program_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [12:0]       prog_wdata,
    input  logic              start,
    input  logic              halt,
    input  logic              step_mode,
`ifdef MCPU_SEQ_BREAKPOINT_EN
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              bp_hit,
`endif
    output logic [3:0]        cpu_opcode,
    output logic [3:0]        cpu_data,
    output logic [3:0]        cpu_addr,
    output logic              cpu_we,
    output logic              issue_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] OP_NOP    = 4'b1011;
    localparam logic [3:0] OP_JUMP   = 4'b1110;
    localparam logic [3:0] OP_HALT   = 4'b1111;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    state_t            dec_state;
    logic [ADDR_W-1:0] pc_q, pc_d, dec_pc;
    logic [12:0]       ir_q, ir_d;
    logic [3:0]        hold_q, hold_d;
    logic [12:0]       mem_q [DEPTH];
    logic [12:0]       fetch_w;
    logic              wr_ok;

    assign fetch_w = mem_q[pc_q];
    assign wr_ok   = (state_q == S_IDLE) || (state_q == S_PAUSE) ||
                     (state_q == S_DONE);

    // Program store is deliberately unreset; it is loaded before a run.
    always_ff @(posedge clk) begin
        if (prog_we && wr_ok) begin
            mem_q[prog_addr] <= prog_wdata;
        end
    end

    always_comb begin
        dec_state = S_ISSUE;
        dec_pc    = pc_q;
        if (fetch_w[12:9] == OP_HALT) begin
            dec_state = S_DONE;
        end else if (fetch_w[12:9] == OP_JUMP) begin
            dec_state = S_FETCH;
            dec_pc    = ADDR_W'(fetch_w[4:1]);
        end
    end

`ifdef MCPU_SEQ_BREAKPOINT_EN
    logic bp_skip_q, bp_skip_d;
    logic bp_hit_q, bp_hit_d;
    assign bp_hit = bp_hit_q;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        hold_d  = hold_q;
`ifdef MCPU_SEQ_BREAKPOINT_EN
        bp_skip_d = bp_skip_q;
        bp_hit_d  = 1'b0;
`endif
        if (halt) begin
            state_d = S_IDLE;
            hold_d  = 4'd0;
`ifdef MCPU_SEQ_BREAKPOINT_EN
            bp_skip_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_FETCH;
                        pc_d    = '0;
`ifdef MCPU_SEQ_BREAKPOINT_EN
                        bp_skip_d = 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    ir_d   = fetch_w;
                    hold_d = 4'd0;
`ifdef MCPU_SEQ_BREAKPOINT_EN
                    if (bp_en && (pc_q == bp_addr) && !bp_skip_q) begin
                        state_d   = S_PAUSE;
                        bp_hit_d  = 1'b1;
                        bp_skip_d = 1'b1;
                    end else begin
                        state_d   = dec_state;
                        pc_d      = dec_pc;
                        bp_skip_d = 1'b0;
                    end
`else
                    state_d = dec_state;
                    pc_d    = dec_pc;
`endif
                end
                S_ISSUE: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = 4'd0;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = step_mode ? S_PAUSE : S_FETCH;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            hold_q  <= hold_d;
        end
    end

`ifdef MCPU_SEQ_BREAKPOINT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_skip_q <= 1'b0;
            bp_hit_q  <= 1'b0;
        end else begin
            bp_skip_q <= bp_skip_d;
            bp_hit_q  <= bp_hit_d;
        end
    end
`endif

    // Outputs decode straight from state so async reset clears them at once.
    always_comb begin
        cpu_opcode  = OP_NOP;
        cpu_data    = 4'd0;
        cpu_addr    = 4'd0;
        cpu_we      = 1'b0;
        issue_valid = 1'b0;
        if (state_q == S_ISSUE) begin
            cpu_opcode  = ir_q[12:9];
            cpu_data    = ir_q[8:5];
            cpu_addr    = ir_q[4:1];
            cpu_we      = ir_q[0];
            issue_valid = 1'b1;
        end
    end

    assign busy = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                  (state_q == S_PAUSE);
    assign done = (state_q == S_DONE);
    assign pc   = pc_q;

endmodule
